conv_kernel_scheduler: RTL and testbench

- Frame-level controller placed in front of the streaming 2D convolution filter.
- Holds a bank of NUM_KERNELS coefficient sets, written through a register-style config port.
- Gates the pixel stream into the filter and drives the filter's kernel input from a shadow register. The shadow changes only at frame boundaries.
- Rotates through a programmable sequence of kernels, one per frame (for example Sobel-X, then Sobel-Y), and reports frame completion on the filter's output side.

---
 rtl/conv_sched_pkg.sv | 34 +++
 rtl/kernel_bank.sv | 58 +++++
 rtl/conv_kernel_scheduler.sv | 157 +++++++++++++++
 tb/tb_conv_kernel_scheduler.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the convolution kernel scheduler.
// Kernel geometry, coefficient width and bank depth are fixed here for every user of the package.
package conv_sched_pkg;

    localparam int W           = 8;
    localparam int KERNEL_H    = 3;
    localparam int KERNEL_W    = 3;
    localparam int NUM_KERNELS = 4;

    localparam int SEL_W  = $clog2(NUM_KERNELS);
    localparam int PASS_W = SEL_W + 1;
    localparam int ROW_W  = $clog2(KERNEL_H);
    localparam int COL_W  = $clog2(KERNEL_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    typedef logic signed [W-1:0] kernel_t [KERNEL_H][KERNEL_W];

    // A request of zero passes still runs one kernel; longer requests saturate at the bank depth.
    function automatic logic [PASS_W-1:0] clamp_passes(input logic [PASS_W-1:0] n);
        if (n == '0) begin
            return PASS_W'(1);
        end
        if (int'(n) > NUM_KERNELS) begin
            return PASS_W'(NUM_KERNELS);
        end
        return n;
    endfunction

endpackage

// File: rtl/kernel_bank.sv
// Coefficient bank: range-checked register-style write port and a combinational
// read of one whole kernel entry.
module kernel_bank
    import conv_sched_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic [ROW_W-1:0]    cfg_row,
    input  logic [COL_W-1:0]    cfg_col,
    input  logic signed [W-1:0] cfg_data,
    output logic                cfg_err,
    input  logic [SEL_W-1:0]    rd_sel,
    output kernel_t             rd_kernel
);

    kernel_t bank_q [NUM_KERNELS];
    kernel_t bank_d [NUM_KERNELS];
    logic    cfg_err_q, cfg_err_d;
    logic    addr_ok;

    always_comb begin
        addr_ok   = (int'(cfg_sel) < NUM_KERNELS) &&
                    (int'(cfg_row) < KERNEL_H) &&
                    (int'(cfg_col) < KERNEL_W);
        bank_d    = bank_q;
        cfg_err_d = 1'b0;
        if (cfg_we) begin
            if (addr_ok) begin
                bank_d[cfg_sel][cfg_row][cfg_col] = cfg_data;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_KERNELS; k++) begin
                for (int r = 0; r < KERNEL_H; r++) begin
                    for (int c = 0; c < KERNEL_W; c++) begin
                        bank_q[k][r][c] <= '0;
                    end
                end
            end
            cfg_err_q <= 1'b0;
        end else begin
            bank_q    <= bank_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Readers sample the pre-edge contents, so a same-edge write never leaks into a copy.
    assign rd_kernel = bank_q[rd_sel];
    assign cfg_err   = cfg_err_q;

endmodule

// File: rtl/conv_kernel_scheduler.sv
// Frame-level controller in front of the 2D convolution filter: gates the pixel
// stream, rotates the active kernel at frame boundaries and reports frame completion.
module conv_kernel_scheduler
    import conv_sched_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [PASS_W-1:0]   num_passes,
    input  logic                cfg_we,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic [ROW_W-1:0]    cfg_row,
    input  logic [COL_W-1:0]    cfg_col,
    input  logic signed [W-1:0] cfg_data,
    output logic                cfg_err,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [W-1:0]        s_data,
    output logic                f_x_valid,
    input  logic                f_x_ready,
    output logic [W-1:0]        f_x_data,
    output kernel_t             kernel,
    input  logic                f_y_valid,
    input  logic                f_y_ready,
    output logic                busy,
    output logic [SEL_W-1:0]    pass_idx,
    output logic                frame_done
);

    localparam int FRAME_PIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int CNT_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIX - 1);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  pass_idx_q, pass_idx_d;
    logic [PASS_W-1:0] passes_q, passes_d;
    logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic              frame_done_q, frame_done_d;
    kernel_t           kernel_q, kernel_d;

    kernel_t           bank_rd;
    logic [SEL_W-1:0]  rd_sel, next_idx;
    logic [PASS_W-1:0] idx_inc;
    logic              running, in_hs, out_hs;

    kernel_bank u_bank (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_row   (cfg_row),
        .cfg_col   (cfg_col),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
        .rd_sel    (rd_sel),
        .rd_kernel (bank_rd)
    );

    assign running   = (state_q == RUN);
    assign s_ready   = f_x_ready && running;
    assign f_x_valid = s_valid && running;
    assign f_x_data  = s_data;
    assign in_hs     = s_valid && s_ready;
    assign out_hs    = f_y_valid && f_y_ready;

    assign idx_inc  = {1'b0, pass_idx_q} + PASS_W'(1);
    assign next_idx = (idx_inc >= passes_q) ? '0 : idx_inc[SEL_W-1:0];
    assign rd_sel   = (state_q == LOAD) ? '0 : next_idx;

    always_comb begin
        state_d    = state_q;
        pass_idx_d = pass_idx_q;
        passes_d   = passes_q;
        in_cnt_d   = in_cnt_q;
        kernel_d   = kernel_q;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                kernel_d   = bank_rd;
                pass_idx_d = '0;
                passes_d   = clamp_passes(num_passes);
                in_cnt_d   = '0;
                state_d    = RUN;
            end
            RUN: begin
                if (in_hs) begin
                    if (in_cnt_q == LAST_PIX) begin
                        // Frame boundary: the next frame's first pixel already sees the new kernel.
                        in_cnt_d   = '0;
                        pass_idx_d = next_idx;
                        kernel_d   = bank_rd;
                        if (!enable) begin
                            state_d = IDLE;
                        end
                    end else begin
                        in_cnt_d = in_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output side keeps counting in every state so late filter results still close the frame.
    always_comb begin
        out_cnt_d    = out_cnt_q;
        frame_done_d = 1'b0;
        if (out_hs) begin
            if (out_cnt_q == LAST_PIX) begin
                out_cnt_d    = '0;
                frame_done_d = 1'b1;
            end else begin
                out_cnt_d = out_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pass_idx_q   <= '0;
            passes_q     <= '0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            frame_done_q <= 1'b0;
            for (int r = 0; r < KERNEL_H; r++) begin
                for (int c = 0; c < KERNEL_W; c++) begin
                    kernel_q[r][c] <= '0;
                end
            end
        end else begin
            state_q      <= state_d;
            pass_idx_q   <= pass_idx_d;
            passes_q     <= passes_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            frame_done_q <= frame_done_d;
            kernel_q     <= kernel_d;
        end
    end

    assign kernel     = kernel_q;
    assign busy       = (state_q != IDLE);
    assign pass_idx   = pass_idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_kernel_scheduler.sv
// Self-checking bench for conv_kernel_scheduler on a 4x3 frame with a 4-entry bank.
module tb_conv_kernel_scheduler;
    import conv_sched_pkg::*;

    localparam int IW    = 4;
    localparam int IH    = 3;
    localparam int FRAME = IW * IH;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                enable;
    logic [PASS_W-1:0]   num_passes;
    logic                cfg_we;
    logic [SEL_W-1:0]    cfg_sel;
    logic [ROW_W-1:0]    cfg_row;
    logic [COL_W-1:0]    cfg_col;
    logic signed [W-1:0] cfg_data;
    logic                cfg_err;
    logic                s_valid;
    logic                s_ready;
    logic [W-1:0]        s_data;
    logic                f_x_valid;
    logic                f_x_ready;
    logic [W-1:0]        f_x_data;
    kernel_t             kernel;
    logic                f_y_valid;
    logic                f_y_ready;
    logic                busy;
    logic [SEL_W-1:0]    pass_idx;
    logic                frame_done;

    always #5 clk = ~clk;

    conv_kernel_scheduler #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .num_passes (num_passes),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_row    (cfg_row),
        .cfg_col    (cfg_col),
        .cfg_data   (cfg_data),
        .cfg_err    (cfg_err),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .f_x_valid  (f_x_valid),
        .f_x_ready  (f_x_ready),
        .f_x_data   (f_x_data),
        .kernel     (kernel),
        .f_y_valid  (f_y_valid),
        .f_y_ready  (f_y_ready),
        .busy       (busy),
        .pass_idx   (pass_idx),
        .frame_done (frame_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: bank contents, active kernel, frame position and pass rotation.
    int m_bank   [NUM_KERNELS][KERNEL_H][KERNEL_W];
    int m_kernel [KERNEL_H][KERNEL_W];
    int m_mode, m_pass, m_npass, m_in, m_out;
    int m_fd, m_err;

    function automatic int addr_in_range(input int s, input int r, input int c);
        return (s < NUM_KERNELS && r < KERNEL_H && c < KERNEL_W) ? 1 : 0;
    endfunction

    function automatic int eff_passes(input int n);
        if (n == 0) return 1;
        if (n > NUM_KERNELS) return NUM_KERNELS;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            foreach (m_bank[k, r, c]) m_bank[k][r][c] <= 0;
            foreach (m_kernel[r, c]) m_kernel[r][c] <= 0;
            m_mode  <= M_IDLE;
            m_pass  <= 0;
            m_npass <= 0;
            m_in    <= 0;
            m_out   <= 0;
            m_fd    <= 0;
            m_err   <= 0;
        end else begin
            m_err <= (cfg_we && addr_in_range(int'(cfg_sel), int'(cfg_row), int'(cfg_col)) == 0) ? 1 : 0;
            if (cfg_we && addr_in_range(int'(cfg_sel), int'(cfg_row), int'(cfg_col)) == 1)
                m_bank[int'(cfg_sel)][int'(cfg_row)][int'(cfg_col)] <= int'(cfg_data);

            m_fd <= 0;
            if (f_y_valid && f_y_ready) begin
                if (m_out == FRAME - 1) begin
                    m_out <= 0;
                    m_fd  <= 1;
                end else begin
                    m_out <= m_out + 1;
                end
            end

            case (m_mode)
                M_IDLE: if (enable) m_mode <= M_LOAD;
                M_LOAD: begin
                    foreach (m_kernel[r, c]) m_kernel[r][c] <= m_bank[0][r][c];
                    m_pass  <= 0;
                    m_npass <= eff_passes(int'(num_passes));
                    m_in    <= 0;
                    m_mode  <= M_RUN;
                end
                M_RUN: if (s_valid && f_x_ready) begin
                    if (m_in == FRAME - 1) begin
                        m_in   <= 0;
                        m_pass <= (m_pass + 1) % m_npass;
                        foreach (m_kernel[r, c]) m_kernel[r][c] <= m_bank[(m_pass + 1) % m_npass][r][c];
                        if (!enable) m_mode <= M_IDLE;
                    end else begin
                        m_in <= m_in + 1;
                    end
                end
                default: m_mode <= M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("s_ready",    int'(s_ready),    int'(f_x_ready && m_mode == M_RUN));
        chk("f_x_valid",  int'(f_x_valid),  int'(s_valid && m_mode == M_RUN));
        chk("f_x_data",   int'(f_x_data),   int'(s_data));
        chk("busy",       int'(busy),       (m_mode != M_IDLE) ? 1 : 0);
        chk("pass_idx",   int'(pass_idx),   m_pass);
        chk("frame_done", int'(frame_done), m_fd);
        chk("cfg_err",    int'(cfg_err),    m_err);
        foreach (m_kernel[r, c]) chk("kernel", int'(kernel[r][c]), m_kernel[r][c]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enable     = 1'b0;
        num_passes = '0;
        cfg_we     = 1'b0;
        cfg_sel    = '0;
        cfg_row    = '0;
        cfg_col    = '0;
        cfg_data   = '0;
        s_valid    = 1'b0;
        s_data     = '0;
        f_x_ready  = 1'b0;
        f_y_valid  = 1'b0;
        f_y_ready  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        step();
    endtask

    task automatic write_bank(input int k, input int v);
        for (int r = 0; r < KERNEL_H; r++) begin
            for (int c = 0; c < KERNEL_W; c++) begin
                cfg_we   = 1'b1;
                cfg_sel  = SEL_W'(k);
                cfg_row  = ROW_W'(r);
                cfg_col  = COL_W'(c);
                cfg_data = W'(v);
                step();
            end
        end
        cfg_we = 1'b0;
    endtask

    task automatic start_run(input int passes);
        num_passes = PASS_W'(passes);
        enable     = 1'b1;
        s_valid    = 1'b1;
        f_x_ready  = 1'b1;
        step();
        step();
    endtask

    int hs, pulses, n;

    initial begin
        idle_inputs();
        do_reset();
        chk("reset_busy",   int'(busy), 0);
        chk("reset_kernel", int'(kernel[2][2]), 0);

        // Rotation across three frames with two passes
        write_bank(0, 1);
        write_bank(1, 2);
        write_bank(2, 3);
        start_run(2);
        chk("rot_load_kernel", int'(kernel[1][1]), 1);
        chk("rot_load_pass",   int'(pass_idx), 0);
        for (int i = 1; i <= 3 * FRAME; i++) begin
            s_data = W'($urandom);
            step();
            if (i == FRAME - 1) chk("rot_pre_switch", int'(kernel[0][0]), 1);
            if (i == FRAME) begin
                chk("rot_f1_kernel", int'(kernel[0][0]), 2);
                chk("rot_f1_pass",   int'(pass_idx), 1);
            end
            if (i == 2 * FRAME) begin
                chk("rot_f2_kernel", int'(kernel[2][1]), 1);
                chk("rot_f2_pass",   int'(pass_idx), 0);
            end
            if (i == 3 * FRAME) chk("rot_f3_pass", int'(pass_idx), 1);
        end

        // Reset mid-stream clears everything within the same cycle
        for (int i = 0; i < 5; i++) step();
        #2 rst = 1'b1;
        #1;
        chk("rst_s_ready",   int'(s_ready), 0);
        chk("rst_f_x_valid", int'(f_x_valid), 0);
        chk("rst_busy",      int'(busy), 0);
        chk("rst_pass_idx",  int'(pass_idx), 0);
        chk("rst_kernel",    int'(kernel[0][0]), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step();

        // Backpressure: f_x_ready toggles every cycle
        do_reset();
        write_bank(0, 1);
        write_bank(1, 2);
        start_run(2);
        hs = 0;
        for (int cyc = 0; cyc < 100 && hs < FRAME; cyc++) begin
            f_x_ready = ((cyc % 2) == 1) ? 1'b1 : 1'b0;
            s_data    = W'($urandom);
            #1;
            chk("bp_mirror", int'(s_ready), int'(f_x_ready));
            if (s_valid && s_ready) begin
                hs++;
                if (hs == FRAME) chk("bp_pre_switch", int'(pass_idx), 0);
            end
            step();
        end
        chk("bp_count",       hs, FRAME);
        chk("bp_switch_pass", int'(pass_idx), 1);
        chk("bp_switch_kern", int'(kernel[1][2]), 2);

        // Stop request after pixel 5: frame still completes
        do_reset();
        write_bank(0, 5);
        start_run(1);
        hs = 0;
        for (int cyc = 0; cyc < 60 && hs < FRAME; cyc++) begin
            if (s_valid && s_ready) hs++;
            s_data = W'($urandom);
            step();
            if (hs == 5) enable = 1'b0;
        end
        chk("stop_count",   hs, FRAME);
        chk("stop_busy",    int'(busy), 0);
        chk("stop_s_ready", int'(s_ready), 0);
        chk("stop_kernel",  int'(kernel[0][0]), 5);
        for (int i = 0; i < 4; i++) step();
        chk("stop_idle_s_ready", int'(s_ready), 0);

        // Out-of-range writes and a write colliding with the boundary copy
        do_reset();
        write_bank(0, 1);
        write_bank(1, 2);
        cfg_we = 1'b1; cfg_sel = 2'd1; cfg_row = 2'd3; cfg_col = 2'd0; cfg_data = 8'sd77;
        step();
        cfg_we = 1'b0;
        chk("cfg_err_row", int'(cfg_err), 1);
        step();
        chk("cfg_err_clear", int'(cfg_err), 0);
        cfg_we = 1'b1; cfg_sel = 2'd1; cfg_row = 2'd0; cfg_col = 2'd3; cfg_data = 8'sd77;
        step();
        cfg_we = 1'b0;
        chk("cfg_err_col", int'(cfg_err), 1);
        start_run(2);
        for (int i = 1; i < FRAME; i++) step();
        cfg_we = 1'b1; cfg_sel = 2'd1; cfg_row = 2'd0; cfg_col = 2'd0; cfg_data = 8'sd9;
        step();
        cfg_we = 1'b0;
        chk("collide_old", int'(kernel[0][0]), 2);
        chk("collide_row", int'(kernel[2][2]), 2);
        for (int i = 0; i < 2 * FRAME; i++) step();
        chk("collide_new",  int'(kernel[0][0]), 9);
        chk("collide_rest", int'(kernel[0][1]), 2);

        // frame_done after 12 output handshakes with gaps, while IDLE
        do_reset();
        n = 0;
        pulses = 0;
        for (int cyc = 0; cyc < 200 && n < FRAME; cyc++) begin
            f_y_valid = 1'($urandom);
            f_y_ready = 1'($urandom);
            #1;
            if (f_y_valid && f_y_ready) n++;
            step();
            if (frame_done) pulses++;
        end
        f_y_valid = 1'b0;
        chk("fd_count",     n, FRAME);
        chk("fd_on_time",   int'(frame_done), 1);
        chk("fd_pulses",    pulses, 1);
        step();
        chk("fd_one_cycle", int'(frame_done), 0);

        // num_passes = 0 keeps bank0 across frames
        do_reset();
        write_bank(0, 1);
        write_bank(1, 2);
        start_run(0);
        for (int i = 1; i <= 2 * FRAME; i++) begin
            step();
            if (i == FRAME) chk("np0_kernel", int'(kernel[0][0]), 1);
        end
        chk("np0_pass", int'(pass_idx), 0);

        // Randomised traffic against the model
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if ((cyc % 50) == 0) enable = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            num_passes = PASS_W'($urandom);
            s_valid    = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            f_x_ready  = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            s_data     = W'($urandom);
            cfg_we     = ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0;
            cfg_sel    = SEL_W'($urandom);
            cfg_row    = ROW_W'($urandom);
            cfg_col    = COL_W'($urandom);
            cfg_data   = W'($urandom);
            f_y_valid  = 1'($urandom);
            f_y_ready  = 1'($urandom);
            step();
        end

        idle_inputs();
        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
